// File: rtl/ysyx_25040129_burst_rd_responder_pkg.sv
// Shared encodings for the burst read responder.
//   burst_e : AXI4 arburst encodings (FIXED / INCR / WRAP / reserved)
//   resp_e  : AXI4 rresp encodings (OKAY / EXOKAY / SLVERR / DECERR)
//   state_e : responder control states
package ysyx_25040129_burst_rd_responder_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_BURST
  } state_e;

  // WRAP bursts must cover a power-of-two span of 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_legal(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/ysyx_25040129_burst_addr_gen.sv
// Combinational beat address helper.
//   addr      : current beat word address (byte address [31:2])
//   len       : latched arlen
//   burst     : latched arburst
//   next_addr : word address of the following beat
//   legal     : burst type / length combination is serviceable
//   in_range  : addr lies inside the memory window
//   index     : array index of addr (valid when in_range)
module ysyx_25040129_burst_addr_gen
  import ysyx_25040129_burst_rd_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned DEPTH_DIG = 12
) (
  input  logic [29:0]          addr,
  input  logic [7:0]           len,
  input  logic [1:0]           burst,
  output logic [29:0]          next_addr,
  output logic                 legal,
  output logic                 in_range,
  output logic [DEPTH_DIG-1:0] index
);

  logic [29:0] mask;
  logic [29:0] offset;

  assign mask     = {22'd0, len};
  assign offset   = addr - BASE_ADDR[31:2];
  // Below-base addresses wrap to large offsets and fail this test as well.
  assign in_range = (offset >> DEPTH_DIG) == '0;
  assign index    = offset[DEPTH_DIG-1:0];

  always_comb begin
    next_addr = addr + 30'd1;
    legal     = 1'b0;
    case (burst_e'(burst))
      BURST_FIXED: begin
        next_addr = addr;
        legal     = 1'b1;
      end
      BURST_INCR: begin
        next_addr = addr + 30'd1;
        legal     = 1'b1;
      end
      BURST_WRAP: begin
        next_addr = (addr & ~mask) | ((addr + 30'd1) & mask);
        legal     = wrap_len_legal(len);
      end
      default: begin
        next_addr = addr + 30'd1;
        legal     = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ysyx_25040129_burst_rd_responder.sv
// AXI4 read-channel burst responder backed by a word-addressed array.
//   clk, rst                  : clock, synchronous active-high reset
//   araddr/arlen/arburst      : burst request, handshake arvalid/arready
//   rdata/rresp/rlast         : beat payload, handshake rvalid/rready
//   ld_en/ld_addr/ld_data     : backdoor word write, active in any state
// After the AR handshake the block idles LATENCY cycles, then returns
// arlen+1 beats. Out-of-window or illegal-burst beats return SLVERR, data 0.
module ysyx_25040129_burst_rd_responder
  import ysyx_25040129_burst_rd_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned DEPTH_DIG = 12,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  input  logic [7:0]  arlen,
  input  logic [1:0]  arburst,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  output logic        rlast,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data
);

  localparam int unsigned WORDS = 1 << DEPTH_DIG;

  logic [31:0] mem [WORDS];

  state_e      state_q, state_d;
  logic [3:0]  lat_q, lat_d;
  logic [7:0]  beat_q, beat_d;
  logic [7:0]  len_q, len_d;
  logic [1:0]  burst_q, burst_d;
  logic [29:0] addr_q, addr_d;
  logic        fresh_q;
  logic [31:0] hold_q;

  logic [29:0]          next_addr;
  logic                 legal;
  logic                 in_range;
  logic [DEPTH_DIG-1:0] rd_idx;
  logic                 beat_ok;

  logic [29:0] ld_off;
  logic        ld_in_range;
  logic        unused_bits;

  assign unused_bits = ^{araddr[1:0], ld_addr[1:0]};

  ysyx_25040129_burst_addr_gen #(
    .BASE_ADDR (BASE_ADDR),
    .DEPTH_DIG (DEPTH_DIG)
  ) u_addr_gen (
    .addr      (addr_q),
    .len       (len_q),
    .burst     (burst_q),
    .next_addr (next_addr),
    .legal     (legal),
    .in_range  (in_range),
    .index     (rd_idx)
  );

  assign ld_off      = ld_addr[31:2] - BASE_ADDR[31:2];
  assign ld_in_range = (ld_off >> DEPTH_DIG) == '0;

  always_ff @(posedge clk) begin
    if (ld_en && ld_in_range) begin
      mem[ld_off[DEPTH_DIG-1:0]] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lat_q   <= '0;
      beat_q  <= '0;
      len_q   <= '0;
      burst_q <= '0;
      addr_q  <= '0;
      fresh_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      beat_q  <= beat_d;
      len_q   <= len_d;
      burst_q <= burst_d;
      addr_q  <= addr_d;
      // A beat is "fresh" on its first presented cycle; afterwards the
      // captured value is replayed so backdoor writes cannot disturb it.
      fresh_q <= (state_d == ST_BURST) && !((state_q == ST_BURST) && !rready);
      hold_q  <= rdata;
    end
  end

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    beat_d  = beat_q;
    len_d   = len_q;
    burst_d = burst_q;
    addr_d  = addr_q;
    arready = 1'b0;
    rvalid  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        arready = 1'b1;
        if (arvalid) begin
          addr_d  = araddr[31:2];
          len_d   = arlen;
          burst_d = arburst;
          beat_d  = '0;
          lat_d   = 4'(LATENCY);
          state_d = (LATENCY == 0) ? ST_BURST : ST_WAIT;
        end
      end
      ST_WAIT: begin
        lat_d = lat_q - 4'd1;
        if (lat_q <= 4'd1) begin
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        rvalid = 1'b1;
        if (rready) begin
          if (beat_q == len_q) begin
            state_d = ST_IDLE;
          end else begin
            addr_d = next_addr;
            beat_d = beat_q + 8'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign beat_ok = legal && in_range;
  assign rlast   = rvalid && (beat_q == len_q);
  assign rresp   = (rvalid && !beat_ok) ? RESP_SLVERR : RESP_OKAY;
  assign rdata   = (rvalid && beat_ok) ? (fresh_q ? mem[rd_idx] : hold_q) : '0;

endmodule

// File: tb/tb_ysyx_25040129_burst_rd_responder.sv
// Directed bench for the burst read responder (LATENCY=2, DEPTH_DIG=12).
module tb_ysyx_25040129_burst_rd_responder;

  localparam int unsigned LAT = 2;
  localparam logic [31:0] D  = 32'h1000_0000;
  localparam logic [1:0]  OK = 2'b00;
  localparam logic [1:0]  SE = 2'b10;

  typedef struct packed {
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [1:0]  arburst;
  } ar_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [7:0]  arlen = '0;
  logic [1:0]  arburst = '0;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b1;
  logic        rlast;
  logic        ld_en = 1'b0;
  logic [31:0] ld_addr = '0;
  logic [31:0] ld_data = '0;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  ar_t   ars[$];
  beat_t exp_q[$];

  always #5 clk = ~clk;

  ysyx_25040129_burst_rd_responder #(
    .BASE_ADDR (32'h8000_0000),
    .DEPTH_DIG (12),
    .LATENCY   (LAT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .araddr  (araddr),
    .arvalid (arvalid),
    .arready (arready),
    .arlen   (arlen),
    .arburst (arburst),
    .rdata   (rdata),
    .rresp   (rresp),
    .rvalid  (rvalid),
    .rready  (rready),
    .rlast   (rlast),
    .ld_en   (ld_en),
    .ld_addr (ld_addr),
    .ld_data (ld_data)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic ar_t mk_ar(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b);
    mk_ar.araddr  = a;
    mk_ar.arlen   = l;
    mk_ar.arburst = b;
  endfunction

  function automatic beat_t mk_b(input logic [31:0] d, input logic [1:0] r);
    mk_b.data = d;
    mk_b.resp = r;
  endfunction

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Handshake and latency check; returns at the negedge of the first beat.
  task automatic issue_ar(input ar_t a);
    @(negedge clk);
    chk("arready_idle", {31'd0, arready}, 32'd1);
    araddr = a.araddr; arlen = a.arlen; arburst = a.arburst; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    for (int i = 0; i < int'(LAT); i++) begin
      chk("rvalid_during_wait", {31'd0, rvalid}, 32'd0);
      @(negedge clk);
    end
    chk("rvalid_first_beat", {31'd0, rvalid}, 32'd1);
  endtask

  task automatic run_burst(input ar_t a);
    beat_t e;
    issue_ar(a);
    for (int b = 0; b <= int'(a.arlen); b++) begin
      if (exp_q.size() == 0) begin
        chk("exp_queue_empty", 32'd1, 32'd0);
        e = mk_b('0, OK);
      end else begin
        e = exp_q.pop_front();
      end
      chk("beat_rvalid", {31'd0, rvalid}, 32'd1);
      chk("beat_rdata", rdata, e.data);
      chk("beat_rresp", {30'd0, rresp}, {30'd0, e.resp});
      chk("beat_rlast", {31'd0, rlast}, (b == int'(a.arlen)) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    chk("post_burst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("post_burst_arready", {31'd0, arready}, 32'd1);
  endtask

  initial begin
    int unsigned accepted;
    logic [4:0] rr_pat;
    logic [4:0] last_pat;

    // Table: requests and the beats each one must return, in order.
    ars.push_back(mk_ar(32'h8000_0010, 8'd3, 2'b01));
    for (int i = 4; i < 8; i++) exp_q.push_back(mk_b(D + 32'(i), OK));
    ars.push_back(mk_ar(32'h8000_0018, 8'd3, 2'b10));
    exp_q.push_back(mk_b(D + 32'd6, OK)); exp_q.push_back(mk_b(D + 32'd7, OK));
    exp_q.push_back(mk_b(D + 32'd4, OK)); exp_q.push_back(mk_b(D + 32'd5, OK));
    ars.push_back(mk_ar(32'h8000_0008, 8'd2, 2'b00));
    for (int i = 0; i < 3; i++) exp_q.push_back(mk_b(D + 32'd2, OK));
    ars.push_back(mk_ar(32'h8000_3FFC, 8'd1, 2'b01));
    exp_q.push_back(mk_b(32'hABCD_0FFF, OK)); exp_q.push_back(mk_b('0, SE));
    ars.push_back(mk_ar(32'h8000_0000, 8'd2, 2'b10));
    for (int i = 0; i < 3; i++) exp_q.push_back(mk_b('0, SE));
    ars.push_back(mk_ar(32'h8000_0000, 8'd0, 2'b11));
    exp_q.push_back(mk_b('0, SE));
    ars.push_back(mk_ar(32'h7FFF_FFFC, 8'd0, 2'b01));
    exp_q.push_back(mk_b('0, SE));
    ars.push_back(mk_ar(32'h8000_0014, 8'd7, 2'b10));
    for (int i = 5; i < 8; i++) exp_q.push_back(mk_b(D + 32'(i), OK));
    for (int i = 0; i < 5; i++) exp_q.push_back(mk_b(D + 32'(i), OK));
    ars.push_back(mk_ar(32'h8000_0013, 8'd0, 2'b01));
    exp_q.push_back(mk_b(D + 32'd4, OK));

    // Preload while reset is held: backdoor writes land in reset cycles.
    @(negedge clk);
    for (int i = 0; i < 8; i++) load(32'h8000_0000 + 32'(4 * i), D + 32'(i));
    load(32'h8000_3FFC, 32'hABCD_0FFF);
    load(32'h8000_4000, 32'hDEAD_BEEF);
    chk("rst_arready", {31'd0, arready}, 32'd1);
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_rlast", {31'd0, rlast}, 32'd0);
    chk("rst_rresp", {30'd0, rresp}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rst = 1'b0;

    foreach (ars[k]) run_burst(ars[k]);

    // Stall sequence; word 2 is overwritten while beat 1 is stalled.
    rready = 1'b0;
    rr_pat = 5'b10100;
    last_pat = 5'b11000;
    accepted = 0;
    issue_ar(mk_ar(32'h8000_0008, 8'd1, 2'b01));
    for (int k = 0; k < 5; k++) begin
      chk("stall_rvalid", {31'd0, rvalid}, 32'd1);
      chk("stall_rdata", rdata, (k < 3) ? D + 32'd2 : D + 32'd3);
      chk("stall_rlast", {31'd0, rlast}, {31'd0, last_pat[k]});
      rready = rr_pat[k];
      if (rvalid && rready) accepted++;
      ld_en = (k == 0);
      ld_addr = 32'h8000_0008;
      ld_data = 32'h5555_0002;
      @(negedge clk);
    end
    ld_en = 1'b0;
    rready = 1'b1;
    chk("stall_accepted", 32'(accepted), 32'd2);
    chk("stall_end_rvalid", {31'd0, rvalid}, 32'd0);
    chk("stall_end_arready", {31'd0, arready}, 32'd1);

    exp_q.push_back(mk_b(32'h5555_0002, OK));
    run_burst(mk_ar(32'h8000_0008, 8'd0, 2'b00));
    load(32'h8000_0008, D + 32'd2);

    // Reset during beat 2 of an 8-beat burst; a backdoor write rides along.
    issue_ar(mk_ar(32'h8000_0000, 8'd7, 2'b01));
    chk("rstmid_beat0", rdata, D);
    @(negedge clk);
    chk("rstmid_beat1", rdata, D + 32'd1);
    rst = 1'b1;
    ld_en = 1'b1; ld_addr = 32'h8000_0020; ld_data = D + 32'd8;
    @(negedge clk);
    chk("rstmid_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rstmid_arready", {31'd0, arready}, 32'd1);
    chk("rstmid_rlast", {31'd0, rlast}, 32'd0);
    rst = 1'b0;
    ld_en = 1'b0;

    exp_q.push_back(mk_b(D + 32'd8, OK));
    run_burst(mk_ar(32'h8000_0020, 8'd0, 2'b01));
    for (int i = 0; i < 8; i++) exp_q.push_back(mk_b(D + 32'(i), OK));
    run_burst(mk_ar(32'h8000_0000, 8'd7, 2'b01));

    chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
